// File: rtl/mul_pipe_ctrl_if.sv
// Request/result handshake bundle for the pipelined multiplier controller.
// master drives requests and result acceptance; slave is the controller.
interface mul_pipe_ctrl_if #(
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [31:0]      in_src1;
    logic [31:0]      in_src2;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_result;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_op, in_src1, in_src2, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag
    );

    modport slave (
        input  in_valid, in_op, in_src1, in_src2, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag
    );
endinterface

// File: rtl/mul_pipe_ctrl.sv
// Two-stage EX multiplier controller: S1 operand regs feed mul_34,
// S2 captures the product. Ports: clk, resetn, flush, busy, bus (slave).
module mul_34 (
    input  logic [33:0] a,
    input  logic [33:0] b,
    output logic [63:0] p
);
    logic [63:0] a_ext;
    logic [63:0] b_ext;

    // Low 64 bits of the 34x34 signed product.
    assign a_ext = {{30{a[33]}}, a};
    assign b_ext = {{30{b[33]}}, b};
    assign p     = a_ext * b_ext;
endmodule

module mul_pipe_ctrl #(
    parameter int TAG_W = 5
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    output logic              busy,
    mul_pipe_ctrl_if.slave    bus
);
    logic             s1_valid;
    logic [1:0]       s1_op;
    logic [31:0]      s1_src1;
    logic [31:0]      s1_src2;
    logic [TAG_W-1:0] s1_tag;

    logic             s2_valid;
    logic [1:0]       s2_op;
    logic [63:0]      s2_prod;
    logic [TAG_W-1:0] s2_tag;

    logic             s1_ready;
    logic             s2_ready;
    logic             load;
    logic             move;
    logic             sign;
    logic [33:0]      op_a;
    logic [33:0]      op_b;
    logic [63:0]      prod;

    assign s2_ready = !s2_valid | bus.out_ready;
    assign s1_ready = !s1_valid | s2_ready;
    assign bus.in_ready = s1_ready & !flush;

    assign load = bus.in_valid & bus.in_ready;
    assign move = s1_valid & s2_ready;

    // Only MULH.WU needs zero extension; the low word is
    // extension-agnostic, so MUL.W rides the signed path.
    assign sign = (s1_op != 2'b10);
    assign op_a = {{2{sign & s1_src1[31]}}, s1_src1};
    assign op_b = {{2{sign & s1_src2[31]}}, s1_src2};

    mul_34 u_mul (
        .a (op_a),
        .b (op_b),
        .p (prod)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_valid <= 1'b0;
            s1_op    <= '0;
            s1_src1  <= '0;
            s1_src2  <= '0;
            s1_tag   <= '0;
            s2_valid <= 1'b0;
            s2_op    <= '0;
            s2_prod  <= '0;
            s2_tag   <= '0;
        end else begin
            if (load) begin
                s1_op   <= bus.in_op;
                s1_src1 <= bus.in_src1;
                s1_src2 <= bus.in_src2;
                s1_tag  <= bus.in_tag;
            end
            if (move) begin
                s2_op   <= s1_op;
                s2_prod <= prod;
                s2_tag  <= s1_tag;
            end
            if (flush) begin
                s1_valid <= 1'b0;
                s2_valid <= 1'b0;
            end else begin
                if (load)
                    s1_valid <= 1'b1;
                else if (move)
                    s1_valid <= 1'b0;
                if (move)
                    s2_valid <= 1'b1;
                else if (bus.out_ready)
                    s2_valid <= 1'b0;
            end
        end
    end

    // op 01 and 10 take the high word; 00 and 11 the low word.
    assign bus.out_result = (s2_op[0] ^ s2_op[1]) ? s2_prod[63:32]
                                                  : s2_prod[31:0];
    assign bus.out_tag    = s2_tag;
    assign bus.out_valid  = s2_valid;
    assign busy           = s1_valid | s2_valid;
endmodule

// File: tb/tb_mul_pipe_ctrl.sv
// Self-checking bench for mul_pipe_ctrl: vector table, corner
// sequences and a randomized run against a queue-based model.
module tb_mul_pipe_ctrl;
    logic clk;
    logic resetn;
    logic flush;
    logic busy;

    mul_pipe_ctrl_if #(.TAG_W(5)) bus ();

    mul_pipe_ctrl #(.TAG_W(5)) dut (
        .clk    (clk),
        .resetn (resetn),
        .flush  (flush),
        .busy   (busy),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
        int          age;
    } ent_t;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  tag;
        logic [31:0] exp;
    } vec_t;

    ent_t q[$];
    int   total = 0;
    int   bad   = 0;
    logic m_acc;
    logic m_pop;
    logic m_fl;

    function automatic logic [31:0] ref_res(logic [1:0] op,
                                            logic [31:0] a,
                                            logic [31:0] b);
        longint          sp;
        longint unsigned up;
        sp = longint'($signed(a)) * longint'($signed(b));
        up = {32'b0, a} * {32'b0, b};
        case (op)
            2'b01:   return sp[63:32];
            2'b10:   return up[63:32];
            default: return up[31:0];
        endcase
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs at the negedge and check all outputs
    // against the model; adv() then applies the edge to the model.
    task automatic drive(logic iv, logic [1:0] op, logic [31:0] a,
                         logic [31:0] b, logic [4:0] tag,
                         logic ordy, logic fl);
        logic m_ir;
        logic m_ov;
        @(negedge clk);
        bus.in_valid  = iv;
        bus.in_op     = op;
        bus.in_src1   = a;
        bus.in_src2   = b;
        bus.in_tag    = tag;
        bus.out_ready = ordy;
        flush         = fl;
        #1;
        m_ir = !fl && (q.size() < 2 || ordy);
        m_ov = q.size() > 0 && q[0].age >= 1;
        chk("in_ready", 64'(bus.in_ready), 64'(m_ir));
        chk("out_valid", 64'(bus.out_valid), 64'(m_ov));
        chk("busy", 64'(busy), 64'(q.size() > 0));
        if (m_ov) begin
            chk("out_result", 64'(bus.out_result), 64'(q[0].res));
            chk("out_tag", 64'(bus.out_tag), 64'(q[0].tag));
        end
        m_acc = iv && m_ir;
        m_pop = m_ov && ordy;
        m_fl  = fl;
        if (m_acc) begin
            ent_t e;
            e.res = ref_res(op, a, b);
            e.tag = tag;
            e.age = -1;
            q.push_back(e);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        if (m_fl) begin
            q.delete();
        end else begin
            if (m_pop)
                void'(q.pop_front());
            foreach (q[i])
                q[i].age++;
        end
    endtask

    task automatic idle(logic ordy);
        drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0, ordy, 1'b0);
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{2'b00, 32'h00000003, 32'h00000005, 5'd7, 32'h0000000F};
        vecs[1] = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1, 32'h00000001};
        vecs[2] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 32'h00000000};
        vecs[3] = '{2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 32'hFFFFFFFE};
        vecs[4] = '{2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4, 32'h00000001};
        vecs[5] = '{2'b01, 32'h80000000, 32'h80000000, 5'd5, 32'h40000000};
        vecs[6] = '{2'b10, 32'h80000000, 32'h80000000, 5'd6, 32'h40000000};
        vecs[7] = '{2'b01, 32'h80000000, 32'h00000002, 5'd8, 32'hFFFFFFFF};

        resetn        = 1'b0;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_op     = 2'b00;
        bus.in_src1   = 32'h0;
        bus.in_src2   = 32'h0;
        bus.in_tag    = 5'd0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_out_result", 64'(bus.out_result), 64'd0);
        chk("rst_out_tag", 64'(bus.out_tag), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        resetn = 1'b1;

        // Single requests: exactly two cycles from acceptance.
        foreach (vecs[i]) begin
            drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b,
                  vecs[i].tag, 1'b1, 1'b0);
            adv();
            idle(1'b1);
            chk("lat_not_early", 64'(bus.out_valid), 64'd0);
            adv();
            idle(1'b1);
            chk("vec_valid", 64'(bus.out_valid), 64'd1);
            chk("vec_result", 64'(bus.out_result), 64'(vecs[i].exp));
            chk("vec_tag", 64'(bus.out_tag), 64'(vecs[i].tag));
            adv();
        end

        // Back-to-back: results on consecutive cycles.
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b,
                  vecs[i].tag, 1'b1, 1'b0);
            if (i >= 3)
                chk("b2b_result", 64'(bus.out_result),
                    64'(vecs[i-2].exp));
            adv();
        end
        for (int i = 3; i <= 4; i++) begin
            idle(1'b1);
            chk("b2b_tail", 64'(bus.out_result), 64'(vecs[i].exp));
            adv();
        end
        idle(1'b1);
        adv();

        // Stall: third request waits until out_ready rises.
        drive(1'b1, 2'b00, 32'd10, 32'd11, 5'd20, 1'b0, 1'b0);
        adv();
        drive(1'b1, 2'b00, 32'd12, 32'd13, 5'd21, 1'b0, 1'b0);
        adv();
        drive(1'b1, 2'b00, 32'd14, 32'd15, 5'd22, 1'b0, 1'b0);
        chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
        chk("stall_result", 64'(bus.out_result), 64'd110);
        adv();
        drive(1'b1, 2'b00, 32'd14, 32'd15, 5'd22, 1'b0, 1'b0);
        chk("stall_hold", 64'(bus.out_result), 64'd110);
        adv();
        drive(1'b1, 2'b00, 32'd14, 32'd15, 5'd22, 1'b1, 1'b0);
        chk("release_in_ready", 64'(bus.in_ready), 64'd1);
        adv();
        for (int i = 0; i < 3; i++) begin
            idle(1'b1);
            adv();
        end
        chk("stall_drained", 64'(q.size()), 64'd0);

        // Flush with both stages full.
        drive(1'b1, 2'b00, 32'd2, 32'd2, 5'd30, 1'b0, 1'b0);
        adv();
        drive(1'b1, 2'b00, 32'd3, 32'd3, 5'd31, 1'b0, 1'b0);
        adv();
        drive(1'b1, 2'b00, 32'd4, 32'd4, 5'd29, 1'b1, 1'b1);
        chk("flush_in_ready", 64'(bus.in_ready), 64'd0);
        adv();
        idle(1'b1);
        chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
        chk("flush_busy", 64'(busy), 64'd0);
        chk("flush_in_ready_after", 64'(bus.in_ready), 64'd1);
        adv();
        for (int i = 0; i < 3; i++) begin
            idle(1'b1);
            adv();
        end

        // Asynchronous reset with S1 occupied.
        drive(1'b1, 2'b00, 32'd7, 32'd9, 5'd3, 1'b0, 1'b0);
        adv();
        idle(1'b0);
        resetn = 1'b0;
        #1;
        chk("areset_out_valid", 64'(bus.out_valid), 64'd0);
        chk("areset_out_result", 64'(bus.out_result), 64'd0);
        chk("areset_busy", 64'(busy), 64'd0);
        q.delete();
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        drive(1'b1, 2'b00, 32'd2, 32'd3, 5'd9, 1'b1, 1'b0);
        adv();
        idle(1'b1);
        chk("post_rst_early", 64'(bus.out_valid), 64'd0);
        adv();
        idle(1'b1);
        chk("post_rst_result", 64'(bus.out_result), 64'd6);
        chk("post_rst_tag", 64'(bus.out_tag), 64'd9);
        adv();

        // Randomized traffic with stalls and flushes.
        for (int n = 0; n < 600; n++) begin
            logic [31:0] a;
            logic [31:0] b;
            case ($urandom_range(0, 3))
                0:       a = 32'h80000000;
                1:       a = 32'hFFFFFFFF;
                default: a = $urandom;
            endcase
            b = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
            drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                  a, b, 5'($urandom_range(0, 31)),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0);
            adv();
        end
        for (int i = 0; i < 4; i++) begin
            idle(1'b1);
            adv();
        end
        chk("final_drained", 64'(q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
